// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : regfile_mp
// Brief    : Parametrised multi-port register file with dual write, optional
//            r0-zero, write-to-read bypass and a per-register busy scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_mp #(
    parameter int WIDTH   = 16,
    parameter int REGBITS = 4,
    parameter int NREAD   = 2,
    parameter int ZERO_R0 = 1,
    parameter int BYPASS  = 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     we0,
    input  logic [REGBITS-1:0]       wa0,
    input  logic [WIDTH-1:0]         wd0,
    input  logic                     we1,
    input  logic [REGBITS-1:0]       wa1,
    input  logic [WIDTH-1:0]         wd1,
    input  logic [NREAD*REGBITS-1:0] ra,
    output logic [NREAD*WIDTH-1:0]   rd,
    output logic [NREAD-1:0]         rd_busy,
    input  logic                     sb_set,
    input  logic [REGBITS-1:0]       sb_addr,
    output logic [2**REGBITS-1:0]    busy_vec
);

    localparam int DEPTH = 2**REGBITS;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0] r_busy;
    logic [DEPTH-1:0] w_busy_next;
    logic             w_we0;
    logic             w_we1;

    // Writes to r0 are dropped when r0 is hard-wired to zero.
    assign w_we0 = we0 && !((ZERO_R0 != 0) && (wa0 == '0));
    assign w_we1 = we1 && !((ZERO_R0 != 0) && (wa1 == '0));

    // Port 1 is assigned last so it wins an address collision.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int n = 0; n < DEPTH; n++) begin
                r_mem[n] <= '0;
            end
        end else begin
            if (w_we0) begin
                r_mem[wa0] <= wd0;
            end
            if (w_we1) begin
                r_mem[wa1] <= wd1;
            end
        end
    end

    // A new issue supersedes a completing write to the same register.
    always_comb begin
        w_busy_next = r_busy;
        if (we0) begin
            w_busy_next[wa0] = 1'b0;
        end
        if (we1) begin
            w_busy_next[wa1] = 1'b0;
        end
        if (sb_set) begin
            w_busy_next[sb_addr] = 1'b1;
        end
        if (ZERO_R0 != 0) begin
            w_busy_next[0] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_next;
        end
    end

    assign busy_vec = r_busy;

    for (genvar i = 0; i < NREAD; i++) begin : g_read
        logic [REGBITS-1:0] w_addr;
        logic [WIDTH-1:0]   w_data;
        logic               w_busy;

        assign w_addr = ra[i*REGBITS +: REGBITS];

        always_comb begin
            w_data = r_mem[w_addr];
            w_busy = r_busy[w_addr];
            if (BYPASS != 0) begin
                if (we1 && (wa1 == w_addr)) begin
                    w_data = wd1;
                    w_busy = 1'b0;
                end else if (we0 && (wa0 == w_addr)) begin
                    w_data = wd0;
                    w_busy = 1'b0;
                end
            end
            // Zero register overrides any stored or forwarded value.
            if ((ZERO_R0 != 0) && (w_addr == '0)) begin
                w_data = '0;
                w_busy = 1'b0;
            end
        end

        assign rd[i*WIDTH +: WIDTH] = w_data;
        assign rd_busy[i]           = w_busy;
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_mp
// Brief    : Self-checking bench for regfile_mp (r0-zero+bypass and plain builds).
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        we0, we1, sb_set;
    logic [3:0]  wa0, wa1, sb_addr;
    logic [15:0] wd0, wd1;
    logic [7:0]  ra;
    logic [31:0] rd_a, rd_b;
    logic [1:0]  rd_busy_a, rd_busy_b;
    logic [15:0] busy_a, busy_b;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: index 0 = ZERO_R0=1/BYPASS=1 build, 1 = ZERO_R0=0/BYPASS=0 build.
    logic [15:0] m_mem [2][16];
    logic [15:0] m_busy [2];
    bit          cfg_on [2] = '{1'b1, 1'b0};

    always #5 clk = ~clk;

    regfile_mp #(.WIDTH(16), .REGBITS(4), .NREAD(2), .ZERO_R0(1), .BYPASS(1)) dut_a (
        .clk(clk), .reset_n(reset_n),
        .we0(we0), .wa0(wa0), .wd0(wd0),
        .we1(we1), .wa1(wa1), .wd1(wd1),
        .ra(ra), .rd(rd_a), .rd_busy(rd_busy_a),
        .sb_set(sb_set), .sb_addr(sb_addr), .busy_vec(busy_a)
    );

    regfile_mp #(.WIDTH(16), .REGBITS(4), .NREAD(2), .ZERO_R0(0), .BYPASS(0)) dut_b (
        .clk(clk), .reset_n(reset_n),
        .we0(we0), .wa0(wa0), .wd0(wd0),
        .we1(we1), .wa1(wa1), .wd1(wd1),
        .ra(ra), .rd(rd_b), .rd_busy(rd_busy_b),
        .sb_set(sb_set), .sb_addr(sb_addr), .busy_vec(busy_b)
    );

    function automatic logic [15:0] exp_rd(int c, logic [3:0] a);
        if (cfg_on[c] && a == 4'd0) return 16'h0000;
        if (cfg_on[c] && we1 && wa1 == a) return wd1;
        if (cfg_on[c] && we0 && wa0 == a) return wd0;
        return m_mem[c][a];
    endfunction

    function automatic logic exp_rbusy(int c, logic [3:0] a);
        if (cfg_on[c] && a == 4'd0) return 1'b0;
        if (cfg_on[c] && ((we1 && wa1 == a) || (we0 && wa0 == a))) return 1'b0;
        return m_busy[c][a];
    endfunction

    task automatic model_clear();
        for (int c = 0; c < 2; c++) begin
            m_busy[c] = '0;
            for (int n = 0; n < 16; n++) m_mem[c][n] = '0;
        end
    endtask

    task automatic model_edge();
        if (!reset_n) return;
        for (int c = 0; c < 2; c++) begin
            if (we0 && !(cfg_on[c] && wa0 == 4'd0)) m_mem[c][wa0] = wd0;
            if (we1 && !(cfg_on[c] && wa1 == 4'd0)) m_mem[c][wa1] = wd1;
            if (we0) m_busy[c][wa0] = 1'b0;
            if (we1) m_busy[c][wa1] = 1'b0;
            if (sb_set && !(cfg_on[c] && sb_addr == 4'd0)) m_busy[c][sb_addr] = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        we0 = 0; we1 = 0; sb_set = 0;
        wa0 = 0; wa1 = 0; sb_addr = 0; wd0 = 0; wd1 = 0;
    endtask

    task automatic test_reset();
        idle();
        ra = 8'h53;
        #1;
        n_checks++;
        if (rd_a !== 32'h0 || rd_b !== 32'h0) begin
            n_errors++; $display("FAIL reset_rd: got %h/%h expected 0", rd_a, rd_b);
        end
        // Writes and issues while held in reset are ignored.
        we0 = 1; wa0 = 5; wd0 = 16'h1234; sb_set = 1; sb_addr = 5;
        tick();
        idle();
        ra = 8'h55;
        #1;
        n_checks++;
        if (rd_a !== 32'h0 || busy_a !== 16'h0 || busy_b !== 16'h0 || rd_busy_b !== 2'b00) begin
            n_errors++; $display("FAIL reset_hold: got rd=%h busy=%h/%h expected 0", rd_a, busy_a, busy_b);
        end
        reset_n = 1;
        we0 = 1; wa0 = 5; wd0 = 16'h1234; sb_set = 1; sb_addr = 8;
        tick();
        idle();
        ra = 8'h55;
        #1;
        n_checks++;
        if (rd_a[15:0] !== 16'h1234 || rd_b[15:0] !== 16'h1234 || busy_a !== 16'h0100) begin
            n_errors++; $display("FAIL reset_write_r5: got %h/%h busy %h expected 1234 busy 0100", rd_a[15:0], rd_b[15:0], busy_a);
        end
        #1;
        reset_n = 0;
        model_clear();
        #1;
        n_checks++;
        if (rd_a[15:0] !== 16'h0 || rd_b[15:0] !== 16'h0 || busy_a !== 16'h0 || busy_b !== 16'h0) begin
            n_errors++; $display("FAIL reset_async: got %h/%h busy %h/%h expected 0", rd_a[15:0], rd_b[15:0], busy_a, busy_b);
        end
        reset_n = 1;
        tick();
    endtask

    task automatic test_dual_write();
        idle();
        we0 = 1; wa0 = 3; wd0 = 16'hAAAA; we1 = 1; wa1 = 3; wd1 = 16'h5555;
        ra = 8'h33;
        #1;
        n_checks++;
        if (rd_a[15:0] !== 16'h5555 || rd_b[15:0] !== 16'h0000) begin
            n_errors++; $display("FAIL dual_bypass: got %h/%h expected 5555/0000", rd_a[15:0], rd_b[15:0]);
        end
        tick();
        idle();
        #1;
        n_checks++;
        if (rd_a !== 32'h5555_5555 || rd_b !== 32'h5555_5555) begin
            n_errors++; $display("FAIL dual_collision: got %h/%h expected 55555555", rd_a, rd_b);
        end
        we0 = 1; wa0 = 2; wd0 = 16'h1111; we1 = 1; wa1 = 4; wd1 = 16'h2222;
        tick();
        idle();
        ra = 8'h42;
        #1;
        n_checks++;
        if (rd_a !== 32'h2222_1111 || rd_b !== 32'h2222_1111) begin
            n_errors++; $display("FAIL dual_distinct: got %h/%h expected 22221111", rd_a, rd_b);
        end
    endtask

    task automatic test_r0();
        idle();
        we0 = 1; wa0 = 0; wd0 = 16'hFFFF; sb_set = 1; sb_addr = 0;
        ra = 8'h00;
        tick();
        idle();
        #1;
        n_checks++;
        if (rd_a !== 32'h0 || busy_a[0] !== 1'b0 || rd_busy_a !== 2'b00) begin
            n_errors++; $display("FAIL r0_zero: got rd=%h busy0=%b expected 0", rd_a, busy_a[0]);
        end
        n_checks++;
        if (rd_b !== 32'hFFFF_FFFF || busy_b[0] !== 1'b1 || rd_busy_b !== 2'b11) begin
            n_errors++; $display("FAIL r0_plain: got rd=%h busy0=%b expected ffffffff busy 1", rd_b, busy_b[0]);
        end
        we1 = 1; wa1 = 0; wd1 = 16'h0F0F;
        tick();
        idle();
        #1;
        n_checks++;
        if (rd_b[15:0] !== 16'h0F0F || busy_b[0] !== 1'b0) begin
            n_errors++; $display("FAIL r0_plain_clear: got %h busy0=%b expected 0f0f busy 0", rd_b[15:0], busy_b[0]);
        end
    endtask

    task automatic test_bypass();
        idle();
        we0 = 1; wa0 = 7; wd0 = 16'h0001;
        tick();
        idle();
        ra = 8'h07;
        we1 = 1; wa1 = 7; wd1 = 16'hBEEF;
        #1;
        n_checks++;
        if (rd_a[15:0] !== 16'hBEEF) begin
            n_errors++; $display("FAIL bypass_on: got %h expected beef", rd_a[15:0]);
        end
        n_checks++;
        if (rd_b[15:0] !== 16'h0001) begin
            n_errors++; $display("FAIL bypass_off_before: got %h expected 0001", rd_b[15:0]);
        end
        tick();
        idle();
        #1;
        n_checks++;
        if (rd_a[15:0] !== 16'hBEEF || rd_b[15:0] !== 16'hBEEF) begin
            n_errors++; $display("FAIL bypass_after: got %h/%h expected beef", rd_a[15:0], rd_b[15:0]);
        end
    endtask

    task automatic test_scoreboard();
        idle();
        ra = 8'h91;
        sb_set = 1; sb_addr = 9;
        tick();
        idle();
        #1;
        n_checks++;
        if (busy_a[9] !== 1'b1 || rd_busy_a[1] !== 1'b1 || busy_b[9] !== 1'b1 || rd_busy_b[1] !== 1'b1) begin
            n_errors++; $display("FAIL sb_set: got %b%b/%b%b expected 11/11", busy_a[9], rd_busy_a[1], busy_b[9], rd_busy_b[1]);
        end
        we0 = 1; wa0 = 9; wd0 = 16'h9999;
        #1;
        n_checks++;
        if (rd_busy_a[1] !== 1'b0 || rd_busy_b[1] !== 1'b1 || rd_a[31:16] !== 16'h9999) begin
            n_errors++; $display("FAIL sb_bypass_busy: got %b/%b %h expected 0/1 9999", rd_busy_a[1], rd_busy_b[1], rd_a[31:16]);
        end
        tick();
        idle();
        #1;
        n_checks++;
        if (busy_a[9] !== 1'b0 || busy_b[9] !== 1'b0 || rd_busy_b[1] !== 1'b0) begin
            n_errors++; $display("FAIL sb_clear: got %b/%b expected 0/0", busy_a[9], busy_b[9]);
        end
    endtask

    task automatic test_set_clear_race();
        idle();
        ra = 8'h06;
        sb_set = 1; sb_addr = 6; we0 = 1; wa0 = 6; wd0 = 16'h6666;
        tick();
        idle();
        #1;
        n_checks++;
        if (rd_a[15:0] !== 16'h6666 || busy_a[6] !== 1'b1 || busy_b[6] !== 1'b1) begin
            n_errors++; $display("FAIL race_set_wins: got %h busy %b/%b expected 6666 busy 1", rd_a[15:0], busy_a[6], busy_b[6]);
        end
        we1 = 1; wa1 = 6; wd1 = 16'h7777;
        tick();
        idle();
        #1;
        n_checks++;
        if (rd_a[15:0] !== 16'h7777 || busy_a[6] !== 1'b0 || busy_b[6] !== 1'b0) begin
            n_errors++; $display("FAIL race_later_clear: got %h busy %b/%b expected 7777 busy 0", rd_a[15:0], busy_a[6], busy_b[6]);
        end
    endtask

    task automatic test_random();
        logic [31:0] got_rd;
        logic [1:0]  got_rb;
        logic [15:0] got_bv;
        logic [3:0]  a;
        for (int it = 0; it < 400; it++) begin
            // Narrow address range half the time to provoke collisions.
            if ($urandom_range(0, 1) == 0) begin
                wa0 = 4'($urandom_range(0, 3)); wa1 = 4'($urandom_range(0, 3));
                sb_addr = 4'($urandom_range(0, 3));
                ra = {4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
            end else begin
                wa0 = 4'($urandom); wa1 = 4'($urandom); sb_addr = 4'($urandom); ra = 8'($urandom);
            end
            we0 = 1'($urandom); we1 = 1'($urandom); sb_set = 1'($urandom);
            wd0 = 16'($urandom); wd1 = 16'($urandom);
            #1;
            for (int c = 0; c < 2; c++) begin
                got_rd = (c == 0) ? rd_a : rd_b;
                got_rb = (c == 0) ? rd_busy_a : rd_busy_b;
                got_bv = (c == 0) ? busy_a : busy_b;
                for (int p = 0; p < 2; p++) begin
                    a = ra[p*4 +: 4];
                    n_checks++;
                    if (got_rd[p*16 +: 16] !== exp_rd(c, a) || got_rb[p] !== exp_rbusy(c, a)) begin
                        n_errors++;
                        $display("FAIL rand_read it=%0d cfg=%0d port=%0d: got %h busy %b expected %h busy %b",
                                 it, c, p, got_rd[p*16 +: 16], got_rb[p], exp_rd(c, a), exp_rbusy(c, a));
                    end
                end
                n_checks++;
                if (got_bv !== m_busy[c]) begin
                    n_errors++; $display("FAIL rand_busy_vec it=%0d cfg=%0d: got %h expected %h", it, c, got_bv, m_busy[c]);
                end
            end
            if ($urandom_range(0, 39) == 0) begin
                reset_n = 0;
                model_clear();
                #1;
                n_checks++;
                if (busy_a !== 16'h0 || busy_b !== 16'h0 || rd_b !== 32'h0) begin
                    n_errors++; $display("FAIL rand_reset it=%0d: got busy %h/%h rd %h expected 0", it, busy_a, busy_b, rd_b);
                end
                reset_n = 1;
            end
            tick();
        end
        idle();
    endtask

    initial begin
        reset_n = 0;
        idle();
        ra = 0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_dual_write();
        test_r0();
        test_bypass();
        test_scoreboard();
        test_set_clear_race();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
